// File: rtl/nv_ram_rwsp_param_if.sv
// Read/write port bundle for nv_ram_rwsp_param: read address/enables, write
// address/data/mask, registered read data and status.
interface nv_ram_rwsp_param_if #(
    parameter int DW         = 6,
    parameter int AW         = 7,
    parameter int MASK_LANES = 1
);
    logic [AW-1:0]         ra;
    logic                  re;
    logic                  ore;
    logic [DW-1:0]         dout;
    logic                  dout_vld;
    logic [AW-1:0]         wa;
    logic                  we;
    logic [MASK_LANES-1:0] wmask;
    logic [DW-1:0]         di;
    logic                  init_done;

    modport master (
        output ra, re, ore, wa, we, wmask, di,
        input  dout, dout_vld, init_done
    );

    modport slave (
        input  ra, re, ore, wa, we, wmask, di,
        output dout, dout_vld, init_done
    );
endinterface

// File: rtl/nv_ram_rwsp_param.sv
// Parametrised 1R/1W synchronous RAM with registered read address, ore-gated
// output register, lane write mask, optional write-to-read bypass and init sweep.
module nv_ram_rwsp_param #(
    parameter int              DW            = 6,
    parameter int              AW            = 7,
    parameter int              DEPTH         = 128,
    parameter int              MASK_LANES    = 1,
    parameter int              BYPASS        = 1,
    parameter int              INIT_ON_RESET = 1,
    parameter logic [DW-1:0]   INIT_VAL      = {DW{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [31:0]              pwrbus_ram_pd,
    nv_ram_rwsp_param_if.slave       bus
);
    localparam int            LW      = DW / MASK_LANES;
    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE_C = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   cnt_r;
    logic [AW-1:0]   cnt_nxt_s;
    logic            init_done_r;
    logic            init_done_nxt_s;
    logic            init_we_s;
    logic [AW-1:0]   ra_d_r;
    logic [DW-1:0]   dout_r;
    logic            dout_vld_r;
    logic            wa_ok_s;
    logic            ra_ok_s;
    logic            usr_we_s;
    logic [DW-1:0]   dout_ram_s;
    logic [DW-1:0]   rdata_s;
    logic [DW-1:0]   mem_r [DEPTH];
    logic            unused_pwr_s;

    // Replace the lanes selected by mask with the new data, keep the rest.
    function automatic logic [DW-1:0] merge_lanes(
        input logic [DW-1:0]         old_v,
        input logic [DW-1:0]         new_v,
        input logic [MASK_LANES-1:0] mask
    );
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < MASK_LANES; i++) begin
            if (mask[i]) begin
                res[i*LW +: LW] = new_v[i*LW +: LW];
            end else begin
                res[i*LW +: LW] = old_v[i*LW +: LW];
            end
        end
        return res;
    endfunction

    assign unused_pwr_s = ^pwrbus_ram_pd;

    // Out-of-range addresses only exist when DEPTH does not fill the address space.
    generate
        if (DEPTH < (2 ** AW)) begin : g_partial
            assign wa_ok_s = ({1'b0, bus.wa} < DEPTH_C);
            assign ra_ok_s = ({1'b0, ra_d_r} < DEPTH_C);
        end else begin : g_full
            assign wa_ok_s = 1'b1;
            assign ra_ok_s = 1'b1;
        end
    endgenerate

    assign usr_we_s = (state_r == ST_READY) & bus.we & wa_ok_s & (|bus.wmask);

    // State, sweep counter and init status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= RST_STATE_C;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            init_done_r <= init_done_nxt_s;
        end
    end

    // Sweep sequencing: one INIT_VAL write per cycle, READY after the last word.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        init_done_nxt_s = init_done_r;
        init_we_s       = 1'b0;
        case (state_r)
            ST_INIT: begin
                init_we_s = 1'b1;
                if (cnt_r == LAST_C) begin
                    state_nxt_s     = ST_READY;
                    init_done_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + AW'(1);
                end
            end
            ST_READY: begin
                init_done_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = RST_STATE_C;
            end
        endcase
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (init_we_s) begin
            mem_r[cnt_r[IW-1:0]] <= INIT_VAL;
        end else if (usr_we_s) begin
            mem_r[bus.wa[IW-1:0]] <= merge_lanes(mem_r[bus.wa[IW-1:0]], bus.di, bus.wmask);
        end
    end

    // Read data seen by the output register, with optional same-edge write merge.
    always_comb begin
        dout_ram_s = '0;
        if (ra_ok_s) begin
            dout_ram_s = mem_r[ra_d_r[IW-1:0]];
        end else begin
            dout_ram_s = '0;
        end
        if ((BYPASS != 0) && usr_we_s && (bus.wa == ra_d_r)) begin
            rdata_s = merge_lanes(dout_ram_s, bus.di, bus.wmask);
        end else begin
            rdata_s = dout_ram_s;
        end
    end

    // Read address and output registers; frozen while the sweep runs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ra_d_r     <= '0;
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
        end else begin
            dout_vld_r <= bus.ore & init_done_r;
            if (state_r == ST_READY) begin
                if (bus.re) begin
                    ra_d_r <= bus.ra;
                end
                if (bus.ore) begin
                    dout_r <= rdata_s;
                end
            end
        end
    end

    assign bus.dout      = dout_r;
    assign bus.dout_vld  = dout_vld_r;
    assign bus.init_done = init_done_r;
endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// Self-checking bench: two 16-bit/100-word builds (bypass on/off) sharing stimulus
// against an array-based reference, plus a default 6-bit/128-word build.
module tb_nv_ram_rwsp_param;
    localparam int AD = 100;
    localparam int CD = 128;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pwr = 32'h0000_0000;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [15:0] mem_m [AD];
    int          rad_m;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_vld;

    always #5 clk = ~clk;

    nv_ram_rwsp_param_if #(.DW(16), .AW(7), .MASK_LANES(2)) aif ();
    nv_ram_rwsp_param_if #(.DW(16), .AW(7), .MASK_LANES(2)) bif ();
    nv_ram_rwsp_param_if #(.DW(6),  .AW(7), .MASK_LANES(1)) cif ();

    assign bif.ra    = aif.ra;
    assign bif.re    = aif.re;
    assign bif.ore   = aif.ore;
    assign bif.wa    = aif.wa;
    assign bif.we    = aif.we;
    assign bif.wmask = aif.wmask;
    assign bif.di    = aif.di;

    nv_ram_rwsp_param #(.DW(16), .AW(7), .DEPTH(AD), .MASK_LANES(2), .BYPASS(1),
                        .INIT_ON_RESET(1), .INIT_VAL(16'h0000))
        u_a (.clk(clk), .rstn(rstn), .pwrbus_ram_pd(pwr), .bus(aif));
    nv_ram_rwsp_param #(.DW(16), .AW(7), .DEPTH(AD), .MASK_LANES(2), .BYPASS(0),
                        .INIT_ON_RESET(1), .INIT_VAL(16'h0000))
        u_b (.clk(clk), .rstn(rstn), .pwrbus_ram_pd(pwr), .bus(bif));
    nv_ram_rwsp_param #(.DW(6), .AW(7), .DEPTH(CD), .MASK_LANES(1), .BYPASS(1),
                        .INIT_ON_RESET(1), .INIT_VAL(6'h00))
        u_c (.clk(clk), .rstn(rstn), .pwrbus_ram_pd(pwr), .bus(cif));

    task automatic idle_ab();
        aif.ra = 7'd0; aif.re = 1'b0; aif.ore = 1'b0;
        aif.wa = 7'd0; aif.we = 1'b0; aif.wmask = 2'b00; aif.di = 16'h0000;
    endtask

    task automatic idle_c();
        cif.ra = 7'd0; cif.re = 1'b0; cif.ore = 1'b0;
        cif.wa = 7'd0; cif.we = 1'b0; cif.wmask = 1'b0; cif.di = 6'h00;
    endtask

    // Reference: word array plus the last captured read address.
    task automatic step();
        logic [15:0] old_v;
        logic [15:0] mrg_v;
        if (aif.ore) begin
            old_v = (rad_m < AD) ? mem_m[rad_m] : 16'h0000;
            mrg_v = old_v;
            if (aif.we && int'(aif.wa) == rad_m && rad_m < AD) begin
                if (aif.wmask[0]) mrg_v[7:0]  = aif.di[7:0];
                if (aif.wmask[1]) mrg_v[15:8] = aif.di[15:8];
            end
            exp_a = mrg_v;
            exp_b = old_v;
        end
        exp_vld = aif.ore;
        if (aif.we && int'(aif.wa) < AD) begin
            if (aif.wmask[0]) mem_m[aif.wa][7:0]  = aif.di[7:0];
            if (aif.wmask[1]) mem_m[aif.wa][15:8] = aif.di[15:8];
        end
        if (aif.re) rad_m = int'(aif.ra);
        @(posedge clk); #1;
    endtask

    task automatic wr_a(input int addr, input logic [15:0] data, input logic [1:0] mask);
        aif.we = 1'b1; aif.wa = 7'(addr); aif.di = data; aif.wmask = mask;
        step();
        aif.we = 1'b0;
    endtask

    task automatic rd_a(input int addr);
        aif.re = 1'b1; aif.ra = 7'(addr);
        step();
        aif.re = 1'b0; aif.ore = 1'b1;
        step();
        aif.ore = 1'b0;
    endtask

    task automatic test_reset();
        int ta = 0;
        int tc = 0;
        idle_ab(); idle_c();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (aif.dout !== 16'h0000 || aif.dout_vld !== 1'b0 || aif.init_done !== 1'b0 ||
            cif.dout !== 6'h00 || cif.dout_vld !== 1'b0 || cif.init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values a=%h/%b/%b c=%h/%b/%b required zeros", aif.dout,
                     aif.dout_vld, aif.init_done, cif.dout, cif.dout_vld, cif.init_done);
        end
        rstn = 1'b1;
        for (int k = 1; k <= 300 && (ta == 0 || tc == 0); k++) begin
            if (ta == 0) begin
                aif.we = 1'(($urandom & 32'd1)); aif.wa = 7'($urandom); aif.di = 16'($urandom);
                aif.wmask = 2'b11; aif.re = 1'b1; aif.ra = 7'($urandom); aif.ore = 1'b1;
            end
            if (tc == 0) begin
                cif.we = 1'b1; cif.wa = 7'($urandom); cif.di = 6'h3f; cif.wmask = 1'b1;
                cif.re = 1'b1; cif.ra = 7'($urandom); cif.ore = 1'b1;
            end
            @(posedge clk); #1;
            if (ta == 0 && aif.init_done) begin
                ta = k; idle_ab();
                n_checks++;
                if (aif.dout !== 16'h0000 || aif.dout_vld !== 1'b0 || bif.init_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL init_outputs a.dout=%h vld=%b b.init_done=%b required 0000/0/1",
                             aif.dout, aif.dout_vld, bif.init_done);
                end
            end
            if (tc == 0 && cif.init_done) begin
                tc = k; idle_c();
            end
        end
        n_checks++;
        if (ta != AD) begin
            n_fail++; $display("FAIL init_len_a got %0d required %0d", ta, AD);
        end
        n_checks++;
        if (tc != CD) begin
            n_fail++; $display("FAIL init_len_c got %0d required %0d", tc, CD);
        end
    endtask

    task automatic test_reset_mid_init();
        int ta = 0;
        rstn = 1'b0; idle_ab(); idle_c();
        @(posedge clk); #1;
        rstn = 1'b1;
        aif.we = 1'b1; aif.wa = 7'd5; aif.di = 16'hffff; aif.wmask = 2'b11;
        aif.re = 1'b1; aif.ra = 7'd5; aif.ore = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        for (int k = 1; k <= 300 && ta == 0; k++) begin
            @(posedge clk); #1;
            if (aif.init_done) begin
                ta = k; idle_ab();
            end
        end
        n_checks++;
        if (ta != AD) begin
            n_fail++; $display("FAIL mid_init_len got %0d required %0d", ta, AD);
        end
        n_checks++;
        if (aif.dout !== 16'h0000 || bif.dout !== 16'h0000) begin
            n_fail++; $display("FAIL mid_init_dout a=%h b=%h required 0000", aif.dout, bif.dout);
        end
        wait (cif.init_done === 1'b1 || $time > 64'd200000);
        @(posedge clk); #1;
        for (int i = 0; i < AD; i++) mem_m[i] = 16'h0000;
        rad_m = 0; exp_a = 16'h0000; exp_b = 16'h0000; exp_vld = 1'b0;
    endtask

    task automatic test_c_default();
        cif.re = 1'b1; cif.ore = 1'b1;
        for (int i = 0; i <= CD; i++) begin
            cif.ra = 7'(i % CD);
            @(posedge clk); #1;
            if (i > 0) begin
                n_checks++;
                if (cif.dout !== 6'h00 || cif.dout_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL c_sweep_read addr=%0d got %h/%b required 00/1", i - 1,
                             cif.dout, cif.dout_vld);
                end
            end
        end
        idle_c();
        cif.we = 1'b1; cif.wmask = 1'b1; cif.wa = 7'd5; cif.di = 6'h2a;
        @(posedge clk); #1;
        cif.wa = 7'd127; cif.di = 6'h15;
        @(posedge clk); #1;
        cif.we = 1'b0;
        for (int j = 0; j < 2; j++) begin
            cif.re = 1'b1; cif.ra = (j == 0) ? 7'd5 : 7'd127;
            @(posedge clk); #1;
            cif.re = 1'b0; cif.ore = 1'b1;
            @(posedge clk); #1;
            cif.ore = 1'b0;
            n_checks++;
            if (cif.dout !== ((j == 0) ? 6'h2a : 6'h15) || cif.dout_vld !== 1'b1) begin
                n_fail++;
                $display("FAIL c_basic_rw j=%0d got %h/%b required %h/1", j, cif.dout,
                         cif.dout_vld, (j == 0) ? 6'h2a : 6'h15);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (cif.dout !== 6'h15 || cif.dout_vld !== 1'b0) begin
            n_fail++; $display("FAIL c_hold got %h/%b required 15/0", cif.dout, cif.dout_vld);
        end
    endtask

    task automatic test_basic();
        rd_a(5);
        n_checks++;
        if (aif.dout !== 16'h0000 || bif.dout !== 16'h0000) begin
            n_fail++; $display("FAIL init_ignored_we a=%h b=%h required 0000", aif.dout, bif.dout);
        end
        wr_a(5, 16'h002a, 2'b11);
        wr_a(99, 16'h0015, 2'b11);
        rd_a(5);
        n_checks++;
        if (aif.dout !== 16'h002a || aif.dout_vld !== 1'b1) begin
            n_fail++; $display("FAIL basic_rd5 got %h/%b required 002a/1", aif.dout, aif.dout_vld);
        end
        rd_a(99);
        n_checks++;
        if (aif.dout !== 16'h0015 || bif.dout !== 16'h0015) begin
            n_fail++; $display("FAIL basic_rd99 a=%h b=%h required 0015", aif.dout, bif.dout);
        end
        aif.re = 1'b1; aif.ra = 7'd5;
        step(); step();
        aif.re = 1'b0;
        n_checks++;
        if (aif.dout !== 16'h0015 || aif.dout_vld !== 1'b0) begin
            n_fail++; $display("FAIL ore_hold got %h/%b required 0015/0", aif.dout, aif.dout_vld);
        end
    endtask

    task automatic test_mask();
        wr_a(3, 16'haaaa, 2'b11);
        wr_a(3, 16'h1234, 2'b01);
        rd_a(3);
        n_checks++;
        if (aif.dout !== 16'haa34 || bif.dout !== 16'haa34) begin
            n_fail++; $display("FAIL mask_lane0 a=%h b=%h required aa34", aif.dout, bif.dout);
        end
        wr_a(3, 16'h5555, 2'b00);
        rd_a(3);
        n_checks++;
        if (aif.dout !== 16'haa34) begin
            n_fail++; $display("FAIL mask_zero got %h required aa34", aif.dout);
        end
    endtask

    task automatic test_bypass();
        wr_a(9, 16'h1111, 2'b11);
        aif.re = 1'b1; aif.ra = 7'd9;
        step();
        aif.re = 1'b0; aif.ore = 1'b1;
        aif.we = 1'b1; aif.wa = 7'd9; aif.di = 16'hbeef; aif.wmask = 2'b10;
        step();
        aif.we = 1'b0; aif.ore = 1'b0;
        n_checks++;
        if (aif.dout !== 16'hbe11 || bif.dout !== 16'h1111) begin
            n_fail++; $display("FAIL bypass_edge a=%h b=%h required be11/1111", aif.dout, bif.dout);
        end
        rd_a(9);
        n_checks++;
        if (aif.dout !== 16'hbe11 || bif.dout !== 16'hbe11) begin
            n_fail++; $display("FAIL bypass_after a=%h b=%h required be11", aif.dout, bif.dout);
        end
    endtask

    task automatic test_boundary();
        wr_a(100, 16'h7777, 2'b11);
        rd_a(100);
        n_checks++;
        if (aif.dout !== 16'h0000 || bif.dout !== 16'h0000) begin
            n_fail++; $display("FAIL oob_read a=%h b=%h required 0000", aif.dout, bif.dout);
        end
        rd_a(0);
        n_checks++;
        if (aif.dout !== 16'h0000) begin
            n_fail++; $display("FAIL oob_alias got %h required 0000", aif.dout);
        end
        wr_a(99, 16'hc3a5, 2'b11);
        rd_a(99);
        n_checks++;
        if (aif.dout !== 16'hc3a5) begin
            n_fail++; $display("FAIL last_word got %h required c3a5", aif.dout);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < AD; i++) wr_a(i, 16'($urandom), 2'b11);
        aif.re = 1'b1; aif.ore = 1'b1;
        for (int i = 0; i <= AD; i++) begin
            aif.ra = 7'(i % AD);
            step();
            if (i > 0) begin
                n_checks++;
                if (aif.dout !== mem_m[i - 1] || aif.dout_vld !== 1'b1 || bif.dout !== mem_m[i - 1]) begin
                    n_fail++;
                    $display("FAIL stream addr=%0d a=%h b=%h vld=%b required %h/1", i - 1,
                             aif.dout, bif.dout, aif.dout_vld, mem_m[i - 1]);
                end
            end
        end
        idle_ab();
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            aif.we    = 1'($urandom_range(0, 1));
            aif.wa    = ($urandom_range(0, 2) == 0) ? 7'(rad_m) : 7'($urandom_range(0, 127));
            aif.wmask = 2'($urandom);
            aif.di    = 16'($urandom);
            aif.re    = 1'($urandom_range(0, 1));
            aif.ra    = ($urandom_range(0, 3) == 0) ? aif.wa : 7'($urandom_range(0, 127));
            aif.ore   = 1'($urandom_range(0, 1));
            step();
            n_checks++;
            if (aif.dout !== exp_a || bif.dout !== exp_b || aif.dout_vld !== exp_vld) begin
                n_fail++;
                $display("FAIL random n=%0d a=%h b=%h vld=%b required %h/%h/%b", n, aif.dout,
                         bif.dout, aif.dout_vld, exp_a, exp_b, exp_vld);
            end
        end
        idle_ab();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < AD; i++) mem_m[i] = 16'h0000;
        rad_m = 0; exp_a = 16'h0000; exp_b = 16'h0000; exp_vld = 1'b0;
        test_reset();
        test_reset_mid_init();
        test_c_default();
        test_basic();
        test_mask();
        test_bypass();
        test_boundary();
        test_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
